// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment display scheduler.
// Segment decode, blank constants and the ownership state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    GAP
  } state_t;

  // Active-low {g,f,e,d,c,b,a}; codes 10-15 render as blank
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_display_scheduler_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr.
// Produces one-hot winner, its index and a valid flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int j;

  // Walk the ring backwards so the closest request to ptr wins last
  always_comb begin
    win   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        win    = '0;
        win[j] = 1'b1;
        idx    = PW'(j);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin owner of the shared 4-digit display with hold time,
// blanked handover gap and continuous anode scan multiplexing.
module seg_display_scheduler
  import seg_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SCAN_DIV    = 100_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 1_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  digits,
  output logic [NUM_REQ-1:0]     grant,
  output logic [6:0]             seg,
  output logic [3:0]             an,
  output logic                   owned
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [PW-1:0]      ptr, ptr_n;
  logic [HW-1:0]      hold_cnt, hold_n;
  logic [GW-1:0]      gap_cnt, gap_n;
  logic [SW-1:0]      scan_cnt, scan_n;
  logic [1:0]         dig_idx, dig_n;
  logic [6:0]         seg_n;
  logic [3:0]         an_n;

  logic [NUM_REQ-1:0] pick;
  logic [PW-1:0]      pick_idx;
  logic               pick_valid;
  logic               drop, others, hold_done, gap_done, show;
  logic [3:0]         nib;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .win   (pick),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign drop      = ~|(req & grant);
  assign others    = |(req & ~grant);
  assign hold_done = (hold_cnt >= HW'(HOLD_CYCLES));
  assign gap_done  = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign owned     = |grant;

  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = OWNED;
          grant_n = pick;
        end
      end
      OWNED: begin
        if (drop || (hold_done && others)) begin
          state_n = GAP;
          grant_n = '0;
        end
      end
      GAP: begin
        if (gap_done) begin
          if (pick_valid) begin
            state_n = OWNED;
            grant_n = pick;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
    if (state_n == OWNED && state != OWNED) begin
      ptr_n = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_comb begin
    hold_n = hold_cnt;
    if (state_n == OWNED && state != OWNED) begin
      hold_n = '0;
    end else if (state == OWNED && !hold_done) begin
      hold_n = hold_cnt + 1'b1;
    end
    gap_n = (state == GAP) ? gap_cnt + 1'b1 : '0;
  end

  always_comb begin
    scan_n = scan_cnt + 1'b1;
    dig_n  = dig_idx;
    if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_n = '0;
      dig_n  = dig_idx + 2'd1;
    end
  end

  // Blank on entry and on release so the pins never show a stale owner
  always_comb begin
    nib = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (grant[i] && dig_idx == 2'(k)) nib = digits[16*i+4*k +: 4];
      end
    end
    show  = (state == OWNED) && (state_n == OWNED);
    seg_n = show ? seg_decode(nib) : SEG_BLANK;
    an_n  = show ? ~(4'b0001 << dig_idx) : AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      scan_cnt <= '0;
      dig_idx  <= '0;
      seg      <= SEG_BLANK;
      an       <= AN_OFF;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gap_cnt  <= gap_n;
      scan_cnt <= scan_n;
      dig_idx  <= dig_n;
      seg      <= seg_n;
      an       <= an_n;
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboarded bench for seg_display_scheduler (4 req, short timings).
// A cycle model pushes expected outputs; each test pops and compares.
module tb_seg_display_scheduler;

  localparam int N    = 4;
  localparam int SCAN = 4;
  localparam int HOLD = 20;
  localparam int GAPC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] digits = '0;
  logic [3:0]  grant;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        owned;

  seg_display_scheduler #(
    .NUM_REQ     (N),
    .SCAN_DIV    (SCAN),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAPC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .digits (digits),
    .grant  (grant),
    .seg    (seg),
    .an     (an),
    .owned  (owned)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs, e;

  int m_state = 0, m_owner = -1, m_ptr = 0;
  int m_hold = 0, m_gap = 0, m_scan = 0, m_dig = 0;
  logic [3:0] m_an = 4'hF;
  logic [6:0] m_seg = 7'h7F;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
          7'h7F, 7'h7F, 7'h7F, 7'h7F};
    return t[d];
  endfunction

  // Reference behaviour for one clock edge given current inputs
  task automatic model();
    int w, ns, no;
    bit show;
    logic [3:0] g;
    if (reset) begin
      m_state = 0; m_owner = -1; m_ptr = 0; m_hold = 0;
      m_gap = 0; m_scan = 0; m_dig = 0;
      m_an = 4'hF; m_seg = 7'h7F;
    end else begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (w < 0 && req[j]) w = j;
      end
      ns = m_state; no = m_owner;
      case (m_state)
        0: if (w >= 0) begin ns = 1; no = w; end
        1: if (!req[m_owner] ||
               (m_hold >= HOLD && (req & ~(4'b1 << m_owner)) != 0)) begin
             ns = 2; no = -1;
           end
        default: if (m_gap == GAPC - 1) begin
             if (w >= 0) begin ns = 1; no = w; end
             else ns = 0;
           end
      endcase
      show = (m_state == 1) && (ns == 1);
      if (show) begin
        m_seg = dec(digits[m_owner*16 + m_dig*4 +: 4]);
        m_an  = ~(4'b1 << m_dig);
      end else begin
        m_seg = 7'h7F;
        m_an  = 4'hF;
      end
      if (ns == 1 && m_state != 1) begin
        m_hold = 0;
        m_ptr  = (no + 1) % N;
      end else if (m_state == 1 && m_hold < HOLD) begin
        m_hold++;
      end
      m_gap = (m_state == 2) ? m_gap + 1 : 0;
      if (m_scan == SCAN - 1) begin
        m_scan = 0; m_dig = (m_dig + 1) % 4;
      end else begin
        m_scan++;
      end
      m_state = ns; m_owner = no;
    end
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
    exp_q.push_back({g, m_an, m_seg, m_owner >= 0});
  endtask

  task automatic step(input logic [3:0] r, input logic rst);
    req = r;
    reset = rst;
    model();
    @(posedge clk);
    #1;
    cyc++;
    obs = {grant, an, seg, owned};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 103; i++) begin
      step(4'b0000, i < 3);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset cyc %0d got %b want %b", cyc, obs, e);
      end
    end
  endtask

  task automatic test_scan();
    int seen4;
    seen4 = 0;
    digits[15:0] = 16'h1234;
    for (int i = 0; i < 60; i++) begin
      if (i == 30) digits[15:0] = 16'hA2B4;
      step(4'b0001, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL scan cyc %0d got %b want %b", cyc, obs, e);
      end
      if (i == 0) begin
        n_checks++;
        if (grant !== 4'b0001) begin
          n_fail++;
          $display("FAIL scan_first_grant got %b want 0001", grant);
        end
      end
      if (an == 4'b1110 && seg == 7'b0011001) seen4++;
    end
    n_checks++;
    if (seen4 == 0) begin
      n_fail++;
      $display("FAIL scan_digit0 got %0d hits want >0", seen4);
    end
    for (int i = 0; i < 8; i++) begin
      step(4'b0000, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL scan_drop cyc %0d got %b want %b", cyc, obs, e);
      end
    end
  endtask

  task automatic test_alternate();
    logic [3:0] seq[$];
    logic [3:0] last;
    last = 4'h0;
    digits = 64'h0000_0000_5678_9012;
    for (int i = 0; i < 122; i++) begin
      step(i < 2 ? 4'b0000 : 4'b0011, i < 2);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL alternate cyc %0d got %b want %b", cyc, obs, e);
      end
      if (grant != 4'h0 && grant != last) seq.push_back(grant);
      if (grant != 4'h0) last = grant;
    end
    n_checks++;
    if (seq.size() < 3 || seq[0] !== 4'b0001 || seq[1] !== 4'b0010 ||
        seq[2] !== 4'b0001) begin
      n_fail++;
      $display("FAIL alternate_order got %0d owners want 0001,0010,0001",
               seq.size());
    end
  endtask

  task automatic test_drop_pending();
    logic [3:0] nxt;
    nxt = 4'h0;
    for (int i = 0; i < 30; i++) begin
      if (i < 2) step(4'b0000, 1'b1);
      else if (i < 7) step(4'b0010, 1'b0);
      else if (i < 12) step(4'b1011, 1'b0);
      else step(4'b1001, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL drop_pending cyc %0d got %b want %b", cyc, obs, e);
      end
      if (i >= 12 && nxt == 4'h0 && grant != 4'h0) nxt = grant;
    end
    n_checks++;
    if (nxt !== 4'b1000) begin
      n_fail++;
      $display("FAIL drop_pending_next got %b want 1000", nxt);
    end
  endtask

  task automatic test_single_hold();
    int bad;
    bad = 0;
    for (int i = 0; i < 203; i++) begin
      step(i < 2 ? 4'b0000 : 4'b0100, i < 2);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL single_hold cyc %0d got %b want %b", cyc, obs, e);
      end
      if (i >= 2 && grant !== 4'b0100) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL single_hold_const got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 22; i++) begin
      if (i < 2 || i == 15) step(4'b0001, 1'b1);
      else if (i < 15) step(4'b0001, 1'b0);
      else if (i == 16) step(4'b0000, 1'b0);
      else step(4'b1000, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d got %b want %b", cyc, obs, e);
      end
      if (i == 15) begin
        n_checks++;
        if ({grant, an, seg} !== {4'h0, 4'hF, 7'h7F}) begin
          n_fail++;
          $display("FAIL reset_mid_blank got %b want 0000_1111_1111111",
                   {grant, an, seg});
        end
      end
    end
    n_checks++;
    if (grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_mid_regrant got %b want 1000", grant);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] r;
    r = 4'h0;
    digits = 64'h9876_5432_10AB_CDEF;
    for (int i = 0; i < 30; i++) begin
      if (i < 2) r = 4'b0000;
      else if (i < 8) r = 4'b0001;
      else if (i < 20) r = 4'b0010;
      else if (i < 22) r = 4'b0100;
      else r = 4'b0000;
      step(r, i < 2);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d got %b want %b", cyc, obs, e);
      end
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) digits = {$urandom, $urandom};
      step(r, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL random cyc %0d got %b want %b", cyc, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_alternate();
    test_drop_pending();
    test_single_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Shares the board's single 4-digit seven-segment display between up to NUM_REQ requester blocks (maths game timer/score, other games, menu). It grants ownership round-robin with a minimum hold time and inserts a blanked handover gap. It also performs the anode scan multiplexing, so requesters only present four digit codes. It sits between the game modules and the top-level seg/an pins.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- SCAN_DIV, 100_000: clk cycles per digit slot
- HOLD_CYCLES, 50_000_000: minimum ownership time before pre-emption by another pending requester
- GAP_CYCLES, 1_000: handover blank duration in clk cycles (>=1)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  level request per requester; held while display is wanted
- digits  in  16*NUM_REQ  requester i uses bits [16i+15:16i]; nibble k is digit k (k=0 rightmost); value 0-9 shown, 10-15 blank
- grant  out  NUM_REQ  one-hot (or zero) current owner, registered
- seg  out  7  active-low segments {g,f,e,d,c,b,a}, registered
- an  out  4  active-low anodes, registered
- owned  out  1  high when any grant bit is set

## Operation
- Reset values: grant=0, owned=0, an=4'b1111, seg=7'b1111111, state IDLE, rr pointer=0, scan/hold/gap counters 0, digit index 0.
- States:
  - IDLE: no owner, display blank. Any req bit set -> OWNED with the round-robin winner.
  - OWNED: owner drives display. Owner drops req -> GAP immediately. Hold counter reaches HOLD_CYCLES and another req bit is set -> GAP. Otherwise stay.
  - GAP: grant=0, an=1111 for GAP_CYCLES cycles. Then -> OWNED with the round-robin winner if any req is set, else IDLE.
- Round-robin: search starts at (last owner + 1) mod NUM_REQ. After reset the search starts at requester 0. The pointer updates only on grant. The released owner is eligible again only if no other req is set.
- Hold counter clears on each grant and saturates at HOLD_CYCLES. With no other requester, the owner keeps the display indefinitely.
- Scan: the scan counter counts 0..SCAN_DIV-1. On wrap, the digit index increments 0->1->2->3->0. The scan runs continuously in all states and is not reset by grant changes.
- Digit index k drives an = ~(1<<k). seg = decode(owner nibble k).
- Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, 10-15=1111111.
- digits is sampled live each cycle. There is no requester-side handshake beyond req/grant. A requester must present valid digits whenever its grant is high.

## Timing
- req rises in IDLE at cycle t -> grant/owned high at t+1. seg/an show owner data from t+2 (output register).
- Owner drops req at t -> grant=0 and an=1111 at t+1. The gap spans cycles t+1..t+GAP_CYCLES. The next grant appears at t+GAP_CYCLES+1.
- Hold expiry with a pending requester at cycle t: same timing as a drop.
- Digit change: an/seg update 1 cycle after the scan counter wraps. an and seg always change in the same cycle.
- The owner's req dropping and a new req rising in the same cycle still produce a full GAP.
- All req bits dropping during GAP -> IDLE at gap end, grant stays 0.
- Reset mid-operation: all outputs take reset values on the next edge, regardless of state.

## Structure
- Package seg_pkg holds:
  - SEG_BLANK=7'b1111111 and AN_OFF=4'b1111
  - the digit-to-segment decode function
  - the state enum {IDLE, OWNED, GAP}
- One sub-module, rr_pick: combinational round-robin winner from req and pointer. It outputs a one-hot winner and a valid flag.
- The scan counter, hold counter and gap counter are widened with $clog2 of their limits.

## Test plan
(all tests use NUM_REQ=4, SCAN_DIV=4, HOLD_CYCLES=20, GAP_CYCLES=2)
- Reset release, no req -> an=1111, seg=1111111, grant=0 for 100 cycles.
- req=0001, digits[15:0]=16'h1234 -> grant=0001 one cycle later; an steps through 1110/1101/1011/0111 every 4 cycles with seg 4/3/2/1; digit code 10 shows blank.
- req=0011 simultaneously after reset -> grant 0001 first; after 20 cycles a 2-cycle gap with an=1111; then grant=0010, and owners alternate while both are held.
- Owner 0010 drops req while req=1001 pending -> gap of 2 cycles, then grant=0100? no: grant=1000 (search starts after 1), never 0001.
- Single requester held for 200 cycles -> no gap, grant constant.
- Assert reset mid-OWNED -> next cycle grant=0, an=1111, seg blank; after release, req=1000 with pointer reset -> grant=1000.
